video_timing_sequencer: RTL

Raster timing controller that owns the horizontal pixel counter and the vertical line counter. It sequences both through ACTIVE/FRONT_PORCH/SYNC/BACK_PORCH phases and drives hsync, vsync, composite sync, blanking and pixel coordinates to the video output path. Timing comes from a shadow register file written by a host. The shadow set is committed to the live set only on a frame boundary, so the raster never tears.

---
 rtl/video_timing_pkg.sv | 38 +++
 rtl/timing_axis.sv | 69 ++++++
 rtl/video_timing_sequencer.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/video_timing_pkg.sv
// rtl/video_timing_pkg.sv - phase type, config field indices and default raster timing
package video_timing_pkg;

  typedef enum logic [1:0] {
    ACT  = 2'd0,
    FP   = 2'd1,
    SYNC = 2'd2,
    BP   = 2'd3
  } phase_t;

  localparam logic [2:0] SEL_HACT  = 3'd0;
  localparam logic [2:0] SEL_HFP   = 3'd1;
  localparam logic [2:0] SEL_HSYNC = 3'd2;
  localparam logic [2:0] SEL_HBP   = 3'd3;
  localparam logic [2:0] SEL_VACT  = 3'd4;
  localparam logic [2:0] SEL_VFP   = 3'd5;
  localparam logic [2:0] SEL_VSYNC = 3'd6;
  localparam logic [2:0] SEL_VBP   = 3'd7;

  localparam int DEF_H_ACT  = 640;
  localparam int DEF_H_FP   = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP   = 48;
  localparam int DEF_V_ACT  = 480;
  localparam int DEF_V_FP   = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP   = 33;

  function automatic phase_t next_phase(input phase_t p);
    case (p)
      ACT:     return FP;
      FP:      return SYNC;
      SYNC:    return BP;
      default: return ACT;
    endcase
  endfunction

endpackage

// File: rtl/timing_axis.sv
// rtl/timing_axis.sv - one raster axis: ACT/FP/SYNC/BP phase FSM with an in-phase counter
// phase_o/count_o are the next-state values; last_o flags the final BP count of the current state.
module timing_axis
  import video_timing_pkg::*;
#(
  parameter int W = 12
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic         step_i,
  input  logic         clear_i,
  input  logic [W-1:0] len_act_i,
  input  logic [W-1:0] len_fp_i,
  input  logic [W-1:0] len_sync_i,
  input  logic [W-1:0] len_bp_i,
  output phase_t       phase_o,
  output logic [W-1:0] count_o,
  output logic         last_o
);

  phase_t       phase_q, phase_d;
  logic [W-1:0] count_q, count_d;
  logic [W-1:0] len_cur;
  logic         at_end;

  always_comb begin
    len_cur = len_bp_i;
    case (phase_q)
      ACT:     len_cur = len_act_i;
      FP:      len_cur = len_fp_i;
      SYNC:    len_cur = len_sync_i;
      default: len_cur = len_bp_i;
    endcase
  end

  // Lengths are never zero, so len-1 cannot underflow.
  assign at_end = (count_q == (len_cur - W'(1)));
  assign last_o = (phase_q == BP) && at_end;

  always_comb begin
    phase_d = phase_q;
    count_d = count_q;
    if (clear_i) begin
      phase_d = ACT;
      count_d = '0;
    end else if (step_i) begin
      if (at_end) begin
        phase_d = next_phase(phase_q);
        count_d = '0;
      end else begin
        count_d = count_q + W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      phase_q <= ACT;
      count_q <= '0;
    end else begin
      phase_q <= phase_d;
      count_q <= count_d;
    end
  end

  assign phase_o = phase_d;
  assign count_o = count_d;

endmodule

// File: rtl/video_timing_sequencer.sv
// rtl/video_timing_sequencer.sv - raster timing controller with shadow/live timing registers
// Timing changes land only on a frame wrap (or immediately while stopped) so the raster never tears.
module video_timing_sequencer
  import video_timing_pkg::*;
#(
  parameter int W      = 12,
  parameter int H_ACT  = DEF_H_ACT,
  parameter int H_FP   = DEF_H_FP,
  parameter int H_SYNC = DEF_H_SYNC,
  parameter int H_BP   = DEF_H_BP,
  parameter int V_ACT  = DEF_V_ACT,
  parameter int V_FP   = DEF_V_FP,
  parameter int V_SYNC = DEF_V_SYNC,
  parameter int V_BP   = DEF_V_BP
) (
  input  logic         CK,
  input  logic         RSTN,
  input  logic         en,
  input  logic         cfg_we,
  input  logic [2:0]   cfg_sel,
  input  logic [W-1:0] cfg_data,
  input  logic         cfg_commit,
  output logic         cfg_pending,
  output logic         hsync,
  output logic         vsync,
  output logic         csync,
  output logic         cblank,
  output logic         frame_start,
  output logic [W-1:0] pix_x,
  output logic [W-1:0] line_y
);

  localparam logic [W-1:0] DEF_CFG [8] = '{
    W'(H_ACT), W'(H_FP), W'(H_SYNC), W'(H_BP),
    W'(V_ACT), W'(V_FP), W'(V_SYNC), W'(V_BP)
  };

  logic [W-1:0] shadow_q [8];
  logic [W-1:0] shadow_d [8];
  logic [W-1:0] live_q   [8];
  logic [W-1:0] live_d   [8];

  logic pending_q, pending_d;
  logic started_q, started_d;

  logic         h_step, v_step, h_last, v_last;
  logic         wrap, apply_wrap, apply_idle, apply;
  phase_t       h_phase, v_phase;
  logic [W-1:0] h_count, v_count;

  logic         hsync_q, vsync_q, csync_q, cblank_q, frame_start_q;
  logic         hsync_d, vsync_d, csync_d, cblank_d, frame_start_d;
  logic         active_d;
  logic [W-1:0] pix_x_q, line_y_q, pix_x_d, line_y_d;

  // The first enabled cycle after reset or an idle commit shows pixel (0,0) without stepping.
  assign h_step     = en && started_q;
  assign v_step     = h_step && h_last;
  assign wrap       = v_step && v_last;
  assign apply_wrap = wrap && pending_q;
  assign apply_idle = !en && pending_q;
  assign apply      = apply_wrap || apply_idle;

  assign pending_d = cfg_commit || (pending_q && !apply);
  assign started_d = apply_idle ? 1'b0 : (started_q || en);

  always_comb begin
    shadow_d = shadow_q;
    if (cfg_we) begin
      shadow_d[cfg_sel] = (cfg_data == '0) ? W'(1) : cfg_data;
    end
    live_d = live_q;
    if (apply) begin
      live_d = shadow_d;
    end
  end

  timing_axis #(.W(W)) u_h_axis (
    .clk_i      (CK),
    .rstn_i     (RSTN),
    .step_i     (h_step),
    .clear_i    (apply_idle),
    .len_act_i  (live_q[SEL_HACT]),
    .len_fp_i   (live_q[SEL_HFP]),
    .len_sync_i (live_q[SEL_HSYNC]),
    .len_bp_i   (live_q[SEL_HBP]),
    .phase_o    (h_phase),
    .count_o    (h_count),
    .last_o     (h_last)
  );

  timing_axis #(.W(W)) u_v_axis (
    .clk_i      (CK),
    .rstn_i     (RSTN),
    .step_i     (v_step),
    .clear_i    (apply_idle),
    .len_act_i  (live_q[SEL_VACT]),
    .len_fp_i   (live_q[SEL_VFP]),
    .len_sync_i (live_q[SEL_VSYNC]),
    .len_bp_i   (live_q[SEL_VBP]),
    .phase_o    (v_phase),
    .count_o    (v_count),
    .last_o     (v_last)
  );

  assign active_d      = en && (h_phase == ACT) && (v_phase == ACT);
  assign hsync_d       = en && (h_phase == SYNC);
  assign vsync_d       = en && (v_phase == SYNC);
  assign csync_d       = hsync_d ^ vsync_d;
  assign cblank_d      = !active_d;
  assign frame_start_d = en && (!started_q || wrap);
  assign pix_x_d       = active_d ? h_count : '0;
  assign line_y_d      = active_d ? v_count : '0;

  always_ff @(posedge CK) begin
    if (!RSTN) begin
      shadow_q      <= DEF_CFG;
      live_q        <= DEF_CFG;
      pending_q     <= 1'b0;
      started_q     <= 1'b0;
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      csync_q       <= 1'b0;
      cblank_q      <= 1'b1;
      frame_start_q <= 1'b0;
      pix_x_q       <= '0;
      line_y_q      <= '0;
    end else begin
      shadow_q      <= shadow_d;
      live_q        <= live_d;
      pending_q     <= pending_d;
      started_q     <= started_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      csync_q       <= csync_d;
      cblank_q      <= cblank_d;
      frame_start_q <= frame_start_d;
      pix_x_q       <= pix_x_d;
      line_y_q      <= line_y_d;
    end
  end

  assign cfg_pending = pending_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign csync       = csync_q;
  assign cblank      = cblank_q;
  assign frame_start = frame_start_q;
  assign pix_x       = pix_x_q;
  assign line_y      = line_y_q;

endmodule
